// File: rtl/async_mmap_responder.sv
// Outstanding-read tracking queue: holds {len, id} per accepted AR burst.
// Latency: push visible at head the cycle after the write; head is combinational.
// Backpressure: full flags the producer; push and pop in one cycle keep the count.
module mmap_track_fifo #(
    parameter int Width    = 9,
    parameter int DepthLog = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [Width-1:0] push_dat,
    input  logic             pop,
    output logic [Width-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int Depth = 1 << DepthLog;

    logic [Width-1:0]    mem_q [Depth];
    logic [DepthLog-1:0] wr_ptr_q, wr_ptr_d;
    logic [DepthLog-1:0] rd_ptr_q, rd_ptr_d;
    logic [DepthLog:0]   cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_dat;
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign full     = cnt_q[DepthLog];
    assign empty    = (cnt_q == '0);
endmodule

// AXI4 subordinate: splits INCR bursts into per-beat FIFO requests, rebuilds B and R.
// Latency: one beat per cycle on W, AR addresses and R; B the cycle after the last W beat.
// Backpressure: WREADY follows write_req_full_n, ARREADY drops while the tracking queue is full.
module async_mmap_responder #(
    parameter int AddrWidth         = 64,
    parameter int DataWidth         = 512,
    parameter int DataWidthBytesLog = 6,
    parameter int TrackDepthLog     = 4
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       s_axi_AWVALID,
    output logic                                       s_axi_AWREADY,
    input  logic [AddrWidth-1:0]                       s_axi_AWADDR,
    input  logic [7:0]                                 s_axi_AWLEN,
    input  logic                                       s_axi_AWID,
    input  logic                                       s_axi_WVALID,
    output logic                                       s_axi_WREADY,
    input  logic [DataWidth-1:0]                       s_axi_WDATA,
    input  logic [DataWidth/8-1:0]                     s_axi_WSTRB,
    input  logic                                       s_axi_WLAST,
    output logic                                       s_axi_BVALID,
    input  logic                                       s_axi_BREADY,
    output logic [1:0]                                 s_axi_BRESP,
    output logic                                       s_axi_BID,
    input  logic                                       s_axi_ARVALID,
    output logic                                       s_axi_ARREADY,
    input  logic [AddrWidth-1:0]                       s_axi_ARADDR,
    input  logic [7:0]                                 s_axi_ARLEN,
    input  logic                                       s_axi_ARID,
    output logic                                       s_axi_RVALID,
    input  logic                                       s_axi_RREADY,
    output logic [DataWidth-1:0]                       s_axi_RDATA,
    output logic                                       s_axi_RLAST,
    output logic                                       s_axi_RID,
    output logic [1:0]                                 s_axi_RRESP,
    output logic [AddrWidth+DataWidth+DataWidth/8-1:0] write_req_din,
    output logic                                       write_req_write,
    input  logic                                       write_req_full_n,
    output logic [AddrWidth-1:0]                       read_addr_din,
    output logic                                       read_addr_write,
    input  logic                                       read_addr_full_n,
    input  logic [DataWidth-1:0]                       read_data_dout,
    input  logic                                       read_data_empty_n,
    output logic                                       read_data_read
);
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_ADDR} r_state_e;

    w_state_e             w_state_q, w_state_d;
    r_state_e             r_state_q, r_state_d;
    logic                 live_q, live_d;
    logic [AddrWidth-1:0] aw_base_q, aw_base_d;
    logic [7:0]           aw_len_q, aw_len_d;
    logic                 aw_id_q, aw_id_d;
    logic [7:0]           w_beat_q, w_beat_d;
    logic                 w_err_q, w_err_d;
    logic [AddrWidth-1:0] ar_base_q, ar_base_d;
    logic [7:0]           ar_len_q, ar_len_d;
    logic [7:0]           ar_beat_q, ar_beat_d;
    logic [7:0]           r_beat_q, r_beat_d;

    logic                 aw_rdy, w_rdy, wr_write, b_vld;
    logic                 ar_rdy, ra_write, trk_push, trk_pop, trk_full, trk_empty;
    logic [8:0]           trk_head;
    logic                 r_vld, r_last, r_hs;
    logic [AddrWidth-1:0] w_addr, ra_addr;

    // Beat addresses advance by one full bus width and wrap at the top of the address space.
    assign w_addr  = aw_base_q + (AddrWidth'(w_beat_q) << DataWidthBytesLog);
    assign ra_addr = ar_base_q + (AddrWidth'(ar_beat_q) << DataWidthBytesLog);
    assign live_d  = 1'b1;

    always_comb begin
        w_state_d = w_state_q;
        aw_base_d = aw_base_q;
        aw_len_d  = aw_len_q;
        aw_id_d   = aw_id_q;
        w_beat_d  = w_beat_q;
        w_err_d   = w_err_q;
        aw_rdy    = 1'b0;
        w_rdy     = 1'b0;
        wr_write  = 1'b0;
        b_vld     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                aw_rdy = live_q;
                if (s_axi_AWVALID && live_q) begin
                    aw_base_d = s_axi_AWADDR;
                    aw_len_d  = s_axi_AWLEN;
                    aw_id_d   = s_axi_AWID;
                    w_beat_d  = '0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                w_rdy    = write_req_full_n;
                wr_write = s_axi_WVALID && write_req_full_n;
                if (wr_write) begin
                    // The burst length is authoritative; a misplaced WLAST only flags SLVERR.
                    w_err_d = w_err_q | (s_axi_WLAST != (w_beat_q == aw_len_q));
                    if (w_beat_q == aw_len_q) w_state_d = W_RESP;
                    else                      w_beat_d  = w_beat_q + 1'b1;
                end
            end
            W_RESP: begin
                b_vld = 1'b1;
                if (s_axi_BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        ar_base_d = ar_base_q;
        ar_len_d  = ar_len_q;
        ar_beat_d = ar_beat_q;
        ar_rdy    = 1'b0;
        ra_write  = 1'b0;
        trk_push  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                ar_rdy = live_q && !trk_full;
                if (s_axi_ARVALID && ar_rdy) begin
                    trk_push  = 1'b1;
                    ar_base_d = s_axi_ARADDR;
                    ar_len_d  = s_axi_ARLEN;
                    ar_beat_d = '0;
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                ra_write = read_addr_full_n;
                if (ra_write) begin
                    if (ar_beat_q == ar_len_q) r_state_d = R_IDLE;
                    else                       ar_beat_d = ar_beat_q + 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // R runs off the tracking queue head, independent of the AR address walker.
    always_comb begin
        r_vld    = read_data_empty_n && !trk_empty;
        r_last   = r_vld && (r_beat_q == trk_head[8:1]);
        r_hs     = r_vld && s_axi_RREADY;
        trk_pop  = r_hs && r_last;
        r_beat_d = r_beat_q;
        if (r_hs) r_beat_d = r_last ? 8'd0 : r_beat_q + 1'b1;
    end

    mmap_track_fifo #(
        .Width    (9),
        .DepthLog (TrackDepthLog)
    ) u_track (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (trk_push),
        .push_dat ({s_axi_ARLEN, s_axi_ARID}),
        .pop      (trk_pop),
        .head_dat (trk_head),
        .full     (trk_full),
        .empty    (trk_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            live_q    <= 1'b0;
            aw_base_q <= '0;
            aw_len_q  <= '0;
            aw_id_q   <= 1'b0;
            w_beat_q  <= '0;
            w_err_q   <= 1'b0;
            ar_base_q <= '0;
            ar_len_q  <= '0;
            ar_beat_q <= '0;
            r_beat_q  <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            live_q    <= live_d;
            aw_base_q <= aw_base_d;
            aw_len_q  <= aw_len_d;
            aw_id_q   <= aw_id_d;
            w_beat_q  <= w_beat_d;
            w_err_q   <= w_err_d;
            ar_base_q <= ar_base_d;
            ar_len_q  <= ar_len_d;
            ar_beat_q <= ar_beat_d;
            r_beat_q  <= r_beat_d;
        end
    end

    assign s_axi_AWREADY   = aw_rdy;
    assign s_axi_WREADY    = w_rdy;
    assign s_axi_BVALID    = b_vld;
    assign s_axi_BRESP     = {b_vld & w_err_q, 1'b0};
    assign s_axi_BID       = b_vld & aw_id_q;
    assign s_axi_ARREADY   = ar_rdy;
    assign s_axi_RVALID    = r_vld;
    assign s_axi_RDATA     = r_vld ? read_data_dout : '0;
    assign s_axi_RLAST     = r_last;
    assign s_axi_RID       = r_vld & trk_head[0];
    assign s_axi_RRESP     = 2'b00;
    assign write_req_din   = wr_write ? {s_axi_WSTRB, s_axi_WDATA, w_addr} : '0;
    assign write_req_write = wr_write;
    assign read_addr_din   = ra_write ? ra_addr : '0;
    assign read_addr_write = ra_write;
    assign read_data_read  = r_hs;
endmodule

// File: tb/tb_async_mmap_responder.sv
// Bench for async_mmap_responder: write-burst vector table, read scoreboard, reset and full-queue corners.
module tb_async_mmap_responder;
    localparam int AW = 64;
    localparam int DW = 512;
    localparam int SW = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          s_axi_AWVALID, s_axi_AWREADY, s_axi_AWID;
    logic [AW-1:0] s_axi_AWADDR;
    logic [7:0]    s_axi_AWLEN;
    logic          s_axi_WVALID, s_axi_WREADY, s_axi_WLAST;
    logic [DW-1:0] s_axi_WDATA;
    logic [SW-1:0] s_axi_WSTRB;
    logic          s_axi_BVALID, s_axi_BREADY, s_axi_BID;
    logic [1:0]    s_axi_BRESP;
    logic          s_axi_ARVALID, s_axi_ARREADY, s_axi_ARID;
    logic [AW-1:0] s_axi_ARADDR;
    logic [7:0]    s_axi_ARLEN;
    logic          s_axi_RVALID, s_axi_RREADY, s_axi_RLAST, s_axi_RID;
    logic [DW-1:0] s_axi_RDATA;
    logic [1:0]    s_axi_RRESP;
    logic [AW+DW+SW-1:0] write_req_din;
    logic          write_req_write, write_req_full_n;
    logic [AW-1:0] read_addr_din;
    logic          read_addr_write, read_addr_full_n;
    logic [DW-1:0] read_data_dout = '0;
    logic          read_data_empty_n = 1'b0;
    logic          read_data_read;

    async_mmap_responder dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_AWVALID(s_axi_AWVALID), .s_axi_AWREADY(s_axi_AWREADY), .s_axi_AWADDR(s_axi_AWADDR),
        .s_axi_AWLEN(s_axi_AWLEN), .s_axi_AWID(s_axi_AWID),
        .s_axi_WVALID(s_axi_WVALID), .s_axi_WREADY(s_axi_WREADY), .s_axi_WDATA(s_axi_WDATA),
        .s_axi_WSTRB(s_axi_WSTRB), .s_axi_WLAST(s_axi_WLAST),
        .s_axi_BVALID(s_axi_BVALID), .s_axi_BREADY(s_axi_BREADY), .s_axi_BRESP(s_axi_BRESP),
        .s_axi_BID(s_axi_BID),
        .s_axi_ARVALID(s_axi_ARVALID), .s_axi_ARREADY(s_axi_ARREADY), .s_axi_ARADDR(s_axi_ARADDR),
        .s_axi_ARLEN(s_axi_ARLEN), .s_axi_ARID(s_axi_ARID),
        .s_axi_RVALID(s_axi_RVALID), .s_axi_RREADY(s_axi_RREADY), .s_axi_RDATA(s_axi_RDATA),
        .s_axi_RLAST(s_axi_RLAST), .s_axi_RID(s_axi_RID), .s_axi_RRESP(s_axi_RRESP),
        .write_req_din(write_req_din), .write_req_write(write_req_write),
        .write_req_full_n(write_req_full_n),
        .read_addr_din(read_addr_din), .read_addr_write(read_addr_write),
        .read_addr_full_n(read_addr_full_n),
        .read_data_dout(read_data_dout), .read_data_empty_n(read_data_empty_n),
        .read_data_read(read_data_read)
    );

    typedef struct packed { logic [63:0] addr; logic [31:0] tag; } wexp_t;
    typedef struct packed { logic id; logic [1:0] resp; } bexp_t;
    typedef struct packed { logic id; logic last; logic [31:0] tag; } rexp_t;
    typedef struct {
        logic [63:0] addr; logic [7:0] len; logic id; int wlast_at; bit toggle; int bhold; logic [1:0] bresp;
    } wvec_t;

    wexp_t       wq[$];
    bexp_t       bq[$];
    rexp_t       rq[$];
    logic [63:0] raq[$];
    logic [63:0] pend_q[$];
    logic [63:0] rdq[$];
    logic        mem_hold = 1'b0;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rtag(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] wtag(input int v, input int b);
        return 32'hD000_0000 | 32'(v << 8) | 32'(b);
    endfunction

    // Response monitor plus a word-addressed memory behind the read FIFOs.
    wexp_t       we;
    bexp_t       be;
    rexp_t       re;
    logic        take_rd, take_ra;
    logic [63:0] ra_seen;
    always begin
        @(negedge clk);
        take_rd = 1'b0;
        take_ra = 1'b0;
        if (rst_n) begin
            if (write_req_write) begin
                if (wq.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
                else begin
                    we = wq.pop_front();
                    check("wr_addr", write_req_din[63:0], we.addr);
                    check("wr_data", 64'(write_req_din[64 +: 32]), 64'(we.tag));
                    check("wr_strb", write_req_din[576 +: 64], {~we.tag, we.tag});
                end
            end
            if (s_axi_BVALID && s_axi_BREADY) begin
                if (bq.size() == 0) check("b_unexpected", 64'd1, 64'd0);
                else begin
                    be = bq.pop_front();
                    check("bid", 64'(s_axi_BID), 64'(be.id));
                    check("bresp", 64'(s_axi_BRESP), 64'(be.resp));
                end
            end
            if (read_addr_write) begin
                if (raq.size() == 0) check("ra_unexpected", 64'd1, 64'd0);
                else check("ra_addr", read_addr_din, raq.pop_front());
                take_ra = 1'b1;
                ra_seen = read_addr_din;
            end
            if (s_axi_RVALID && s_axi_RREADY) begin
                check("rd_read", 64'(read_data_read), 64'd1);
                if (rq.size() == 0) check("r_unexpected", 64'd1, 64'd0);
                else begin
                    re = rq.pop_front();
                    check("rid", 64'(s_axi_RID), 64'(re.id));
                    check("rlast", 64'(s_axi_RLAST), 64'(re.last));
                    check("rdata", 64'(s_axi_RDATA[31:0]), 64'(re.tag));
                    check("rresp", 64'(s_axi_RRESP), 64'd0);
                end
                take_rd = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            rdq.delete();
            pend_q.delete();
        end else begin
            if (take_rd) void'(rdq.pop_front());
            if (take_ra) pend_q.push_back(ra_seen);
            if (!mem_hold) while (pend_q.size() > 0) rdq.push_back(pend_q.pop_front());
        end
        read_data_empty_n = (rdq.size() > 0);
        read_data_dout    = (rdq.size() > 0) ? {16{rtag(rdq[0])}} : '0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_send(input logic [63:0] a, input logic [7:0] len, input logic id);
        bit ok = 0;
        s_axi_AWVALID = 1'b1; s_axi_AWADDR = a; s_axi_AWLEN = len; s_axi_AWID = id;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_axi_AWREADY) begin
                ok = 1;
                check("wready_idle", 64'(s_axi_WREADY), 64'd0);
                break;
            end
            tick();
        end
        check("aw_accept", 64'(ok), 64'd1);
        if (ok) tick();
        s_axi_AWVALID = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] tag, input logic last, input bit toggle);
        bit ok = 0;
        s_axi_WVALID = 1'b1; s_axi_WDATA = {16{tag}}; s_axi_WSTRB = {~tag, tag}; s_axi_WLAST = last;
        for (int i = 0; i < 100; i++) begin
            if (toggle) write_req_full_n = ~write_req_full_n;
            @(negedge clk);
            check("wready_fulln", 64'(s_axi_WREADY), 64'(write_req_full_n));
            if (s_axi_WREADY) begin
                ok = 1;
                break;
            end
            tick();
        end
        check("w_accept", 64'(ok), 64'd1);
        if (ok) tick();
        s_axi_WVALID = 1'b0;
    endtask

    task automatic b_wait(input int hold);
        s_axi_BREADY = (hold == 0);
        for (int i = 0; i <= hold; i++) begin
            if (i == hold) s_axi_BREADY = 1'b1;
            @(negedge clk);
            check("bvalid", 64'(s_axi_BVALID), 64'd1);
            check("awready_in_b", 64'(s_axi_AWREADY), 64'd0);
            tick();
        end
        @(negedge clk);
        check("bvalid_drop", 64'(s_axi_BVALID), 64'd0);
        check("awready_after_b", 64'(s_axi_AWREADY), 64'd1);
        tick();
    endtask

    task automatic ar_send(input logic [63:0] a, input logic [7:0] len, input logic id);
        bit ok = 0;
        for (int b = 0; b <= int'(len); b++) begin
            raq.push_back(a + 64'(b * 64));
            rq.push_back('{id: id, last: (b == int'(len)), tag: rtag(a + 64'(b * 64))});
        end
        s_axi_ARVALID = 1'b1; s_axi_ARADDR = a; s_axi_ARLEN = len; s_axi_ARID = id;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_axi_ARREADY) begin
                ok = 1;
                break;
            end
            tick();
        end
        check("ar_accept", 64'(ok), 64'd1);
        if (ok) tick();
        s_axi_ARVALID = 1'b0;
    endtask

    task automatic r_drain(input bit rand_rdy);
        for (int i = 0; i < 400 && rq.size() > 0; i++) begin
            s_axi_RREADY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
        end
        s_axi_RREADY = 1'b0;
        check("r_drained", 64'(rq.size()), 64'd0);
        check("ra_drained", 64'(raq.size()), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vec_cnt);
        $fatal(1, "watchdog");
    end

    wvec_t wv[5];
    bit    ok;

    initial begin
        wv[0] = '{64'h1000, 8'd3, 1'b1, 3, 1'b0, 0, 2'b00};
        wv[1] = '{64'h1000, 8'd3, 1'b0, 1, 1'b0, 0, 2'b10};
        wv[2] = '{64'h2000, 8'd7, 1'b1, 7, 1'b1, 0, 2'b00};
        wv[3] = '{64'hFFFF_FFFF_FFFF_FFC0, 8'd1, 1'b0, 1, 1'b0, 2, 2'b00};
        wv[4] = '{64'h3000, 8'd0, 1'b1, -1, 1'b0, 0, 2'b10};

        s_axi_AWVALID = 1'b1; s_axi_AWADDR = '0; s_axi_AWLEN = '0; s_axi_AWID = 1'b0;
        s_axi_WVALID = 1'b1; s_axi_WDATA = '0; s_axi_WSTRB = '0; s_axi_WLAST = 1'b0;
        s_axi_BREADY = 1'b1;
        s_axi_ARVALID = 1'b1; s_axi_ARADDR = '0; s_axi_ARLEN = '0; s_axi_ARID = 1'b0;
        s_axi_RREADY = 1'b1;
        write_req_full_n = 1'b1;
        read_addr_full_n = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 64'(s_axi_AWREADY), 64'd0);
        check("rst_arready", 64'(s_axi_ARREADY), 64'd0);
        check("rst_wready", 64'(s_axi_WREADY), 64'd0);
        check("rst_bvalid", 64'(s_axi_BVALID), 64'd0);
        check("rst_rvalid", 64'(s_axi_RVALID), 64'd0);
        check("rst_wr_write", 64'(write_req_write), 64'd0);
        check("rst_ra_write", 64'(read_addr_write), 64'd0);
        s_axi_AWVALID = 1'b0; s_axi_ARVALID = 1'b0; s_axi_WVALID = 1'b0; s_axi_RREADY = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("awready_pre_edge", 64'(s_axi_AWREADY), 64'd0);
        check("arready_pre_edge", 64'(s_axi_ARREADY), 64'd0);
        tick();
        @(negedge clk);
        check("awready_rise", 64'(s_axi_AWREADY), 64'd1);
        check("arready_rise", 64'(s_axi_ARREADY), 64'd1);
        tick();

        for (int v = 0; v < 5; v++) begin
            for (int b = 0; b <= int'(wv[v].len); b++)
                wq.push_back('{addr: wv[v].addr + 64'(b * 64), tag: wtag(v, b)});
            bq.push_back('{id: wv[v].id, resp: wv[v].bresp});
            aw_send(wv[v].addr, wv[v].len, wv[v].id);
            for (int b = 0; b <= int'(wv[v].len); b++)
                w_send(wtag(v, b), (b == wv[v].wlast_at), wv[v].toggle);
            write_req_full_n = 1'b1;
            b_wait(wv[v].bhold);
            check("w_beats_done", 64'(wq.size()), 64'd0);
            check("b_done", 64'(bq.size()), 64'd0);
        end

        // Two reads returned in order under random RREADY.
        ar_send(64'h0, 8'd1, 1'b0);
        ar_send(64'h200, 8'd0, 1'b1);
        r_drain(1'b1);

        // Fill the tracking queue with data held back, then free one slot.
        mem_hold = 1'b1;
        for (int i = 0; i < 16; i++) ar_send(64'h8000 + 64'(i * 64), 8'd0, 1'(i));
        repeat (3) tick();
        for (int b = 0; b < 1; b++) begin
            raq.push_back(64'h9000);
            rq.push_back('{id: 1'b1, last: 1'b1, tag: rtag(64'h9000)});
        end
        s_axi_ARVALID = 1'b1; s_axi_ARADDR = 64'h9000; s_axi_ARLEN = 8'd0; s_axi_ARID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arready_full", 64'(s_axi_ARREADY), 64'd0);
            tick();
        end
        mem_hold = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_axi_RVALID) begin
                ok = 1;
                break;
            end
            tick();
        end
        check("rvalid_after_release", 64'(ok), 64'd1);
        check("arready_still_full", 64'(s_axi_ARREADY), 64'd0);
        tick();
        s_axi_RREADY = 1'b1;
        @(negedge clk);
        check("arready_at_rlast", 64'(s_axi_ARREADY), 64'd0);
        tick();
        s_axi_RREADY = 1'b0;
        @(negedge clk);
        check("arready_reraise", 64'(s_axi_ARREADY), 64'd1);
        tick();
        s_axi_ARVALID = 1'b0;
        r_drain(1'b0);

        // Reset in the middle of a write burst, then a clean single-beat write.
        for (int b = 0; b < 4; b++) wq.push_back('{addr: 64'h6000 + 64'(b * 64), tag: wtag(8, b)});
        bq.push_back('{id: 1'b1, resp: 2'b00});
        aw_send(64'h6000, 8'd3, 1'b1);
        w_send(wtag(8, 0), 1'b0, 1'b0);
        w_send(wtag(8, 1), 1'b0, 1'b0);
        s_axi_WVALID = 1'b1; s_axi_WDATA = {16{wtag(8, 2)}}; s_axi_WSTRB = '1; s_axi_WLAST = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_awready", 64'(s_axi_AWREADY), 64'd0);
        check("mid_rst_wready", 64'(s_axi_WREADY), 64'd0);
        check("mid_rst_wr_write", 64'(write_req_write), 64'd0);
        check("mid_rst_wr_din", write_req_din[63:0], 64'd0);
        check("mid_rst_bvalid", 64'(s_axi_BVALID), 64'd0);
        check("mid_rst_arready", 64'(s_axi_ARREADY), 64'd0);
        wq.delete();
        bq.delete();
        s_axi_WVALID = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("awready_pre_edge2", 64'(s_axi_AWREADY), 64'd0);
        tick();
        wq.push_back('{addr: 64'h7000, tag: wtag(9, 0)});
        bq.push_back('{id: 1'b0, resp: 2'b00});
        aw_send(64'h7000, 8'd0, 1'b0);
        w_send(wtag(9, 0), 1'b1, 1'b0);
        b_wait(0);
        check("post_rst_w_done", 64'(wq.size()), 64'd0);
        check("post_rst_b_done", 64'(bq.size()), 64'd0);
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
